product_accumulator_taint_track: RTL

Downstream consumer of the taint-tracked sequential multiplier. It detects each completed product via the rising edge of `productDone` and sums `COUNT` consecutive products into a widened accumulator. It then presents the sum on a valid/ready output port. Every data and control signal carries a bitwise `_t` taint companion, propagated conservatively, including control-flow (implicit) taint.

---
 rtl/multiplier_taint_pkg.sv | 30 +++
 rtl/taint_carry_prop.sv | 21 ++
 rtl/product_accumulator_taint_track.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/multiplier_taint_pkg.sv
// Shared types and helpers for taint-tracked multiplier consumers.
// Holds the accumulator state encoding, guard-bit width derivation and the carry taint rule.
package multiplier_taint_pkg;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_EMIT  = 1'b1
    } acc_state_t;

    // Widest taint vector the prefix-OR helper handles.
    localparam int TAINT_MAX_W = 64;

    function automatic int acc_width(input int width, input int extra);
        return 2 * width + extra;
    endfunction

    // Bit idx of an adder result is tainted if any operand bit at or below it is,
    // since carries only ever move information upward.
    function automatic logic prefix_or_bit(input logic [TAINT_MAX_W-1:0] v, input int idx);
        logic r;
        r = 1'b0;
        for (int j = 0; j < TAINT_MAX_W; j++) begin
            if (j <= idx) begin
                r = r | v[j];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/taint_carry_prop.sv
// Purpose: prefix-OR of a taint vector (carry taint of an adder), N <= 64.
// Latency: combinational.
// Backpressure: none.
module taint_carry_prop
    import multiplier_taint_pkg::*;
#(
    parameter int N = 10
) (
    input  logic [N-1:0] taint_in,
    output logic [N-1:0] taint_out
);

    logic [TAINT_MAX_W-1:0] taint_wide;

    assign taint_wide = TAINT_MAX_W'(taint_in);

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign taint_out[i] = prefix_or_bit(taint_wide, i);
    end

endmodule

// File: rtl/product_accumulator_taint_track.sv
// Purpose: sum COUNT multiplier products (one per productDone rising edge), with taint tracking.
// Latency: sum_valid rises the cycle after the COUNT-th pulse.
// Backpressure: sum held until out_ready; a product arriving while blocked is dropped and flagged.
module product_accumulator_taint_track
    import multiplier_taint_pkg::*;
#(
    parameter  int WIDTH     = 4,
    parameter  int COUNT     = 4,
    parameter  int ACC_EXTRA = 2,
    localparam int ACC_W     = acc_width(WIDTH, ACC_EXTRA)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2*WIDTH-1:0] product,
    input  logic [2*WIDTH-1:0] product_t,
    input  logic               productDone,
    input  logic               productDone_t,
    input  logic               out_ready,
    input  logic               out_ready_t,
    output logic [ACC_W-1:0]   sum,
    output logic [ACC_W-1:0]   sum_t,
    output logic               sum_valid,
    output logic               sum_valid_t,
    output logic               drop_err,
    output logic               drop_err_t
);

    localparam int               CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(COUNT - 1);

    acc_state_t       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             drop_q, drop_d;
    logic             done_prev_q;

    logic [ACC_W-1:0] acc_t_q, acc_t_d;
    logic             ctrl_t_q, done_prev_t_q, drop_t_q;

    logic             pulse, pulse_t, is_emit, handshake, ctrl_now, acc_we;
    logic [ACC_W-1:0] product_w, product_t_w, add_in_t, add_t;

    assign pulse       = productDone & ~done_prev_q;
    assign pulse_t     = productDone_t | done_prev_t_q;
    assign is_emit     = (state_q == ST_EMIT);
    assign handshake   = is_emit & out_ready;
    assign product_w   = ACC_W'(product);
    assign product_t_w = ACC_W'(product_t);

    // Any tainted decision input taints every write from this cycle onward,
    // including the one it steers right now.
    assign ctrl_now = ctrl_t_q | pulse_t | (is_emit & (out_ready_t | productDone_t));

    // On handshake+pulse the accumulator restarts from zero, so old taint is masked.
    assign add_in_t = (handshake ? '0 : acc_t_q) | product_t_w;

    taint_carry_prop #(.N(ACC_W)) u_carry_taint (
        .taint_in  (add_in_t),
        .taint_out (add_t)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        acc_d   = acc_q;
        drop_d  = drop_q;
        acc_we  = 1'b0;
        case (state_q)
            ST_ACCUM: begin
                if (pulse) begin
                    acc_we = 1'b1;
                    acc_d  = acc_q + product_w;
                    if (count_q == LAST) begin
                        count_d = '0;
                        state_d = ST_EMIT;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    acc_we  = 1'b1;
                    acc_d   = '0;
                    count_d = '0;
                    state_d = ST_ACCUM;
                    if (pulse) begin
                        acc_d = product_w;
                        if (COUNT == 1) begin
                            state_d = ST_EMIT;
                        end else begin
                            count_d = CNT_W'(1);
                        end
                    end
                end else if (pulse) begin
                    drop_d = 1'b1;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    always_comb begin
        acc_t_d = acc_t_q;
        if (acc_we) begin
            if (ctrl_now) begin
                acc_t_d = '1;
            end else if (pulse) begin
                acc_t_d = add_t;
            end else begin
                acc_t_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ACCUM;
            count_q     <= '0;
            acc_q       <= '0;
            drop_q      <= 1'b0;
            done_prev_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            acc_q       <= acc_d;
            drop_q      <= drop_d;
            done_prev_q <= productDone;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_t_q       <= '0;
            ctrl_t_q      <= 1'b0;
            done_prev_t_q <= 1'b0;
            drop_t_q      <= 1'b0;
        end else begin
            acc_t_q       <= acc_t_d;
            ctrl_t_q      <= ctrl_now;
            done_prev_t_q <= productDone_t;
            drop_t_q      <= drop_t_q | ctrl_t_q;
        end
    end

    assign sum         = acc_q;
    assign sum_t       = acc_t_q;
    assign sum_valid   = is_emit;
    assign sum_valid_t = ctrl_t_q;
    assign drop_err    = drop_q;
    assign drop_err_t  = ctrl_t_q | drop_t_q;

endmodule
